// File: rtl/cyphertext_serializer_pkg.sv
// Shared sizing constants for the ciphertext byte serializer and its block FIFO.
// The defaults mirror TEXT_WIDTH, BYTE_WIDTH and SER_DEPTH of the AES core.
package cyphertext_serializer_pkg;

  localparam int TEXT_WIDTH_DEF = 128;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int SER_DEPTH      = 2;

endpackage

// File: rtl/cyphertext_serializer_block_fifo.sv
// DEPTH x TEXT_WIDTH register FIFO holding whole ciphertext blocks.
// The head entry is presented combinationally on data_o; storage is never reset.
module block_fifo
  import cyphertext_serializer_pkg::*;
#(
  parameter int DEPTH      = SER_DEPTH,
  parameter int TEXT_WIDTH = TEXT_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [TEXT_WIDTH-1:0]   data_i,
  output logic [TEXT_WIDTH-1:0]   data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TEXT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Data path only; a push into a full FIFO is only issued alongside a pop.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);

endmodule

// File: rtl/cyphertext_serializer.sv
// Captures AES ciphertext blocks on finish_i and streams them MSB byte first
// over a valid/ready handshake; outputs depend only on registered state.
module cyphertext_serializer
  import cyphertext_serializer_pkg::*;
#(
  parameter int TEXT_WIDTH = TEXT_WIDTH_DEF,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int DEPTH      = SER_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    finish_i,
  input  logic [TEXT_WIDTH-1:0]   cyphertext_i,
  output logic [BYTE_WIDTH-1:0]   byte_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    block_done_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int NBYTES = TEXT_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = $clog2(NBYTES);

  logic [TEXT_WIDTH-1:0] head;
  logic [IDX_W-1:0]      byte_idx;
  logic                  full;
  logic                  empty;
  logic                  xfer;
  logic                  last_byte;
  logic                  pop;
  logic                  push;

  function automatic logic [BYTE_WIDTH-1:0] pick_byte(input logic [TEXT_WIDTH-1:0] blk,
                                                      input logic [IDX_W-1:0]      idx);
    logic [TEXT_WIDTH-1:0] shifted;
    shifted = blk << (BYTE_WIDTH * idx);
    return shifted[TEXT_WIDTH-1 -: BYTE_WIDTH];
  endfunction

  assign valid_o   = !empty;
  assign xfer      = valid_o && ready_i;
  assign last_byte = (byte_idx == IDX_W'(NBYTES - 1));
  assign pop       = xfer && last_byte;
  // A full FIFO still takes a new block when its head leaves in the same cycle.
  assign push      = finish_i && (!full || pop);
  assign byte_o    = valid_o ? pick_byte(head, byte_idx) : '0;

  block_fifo #(
    .DEPTH      (DEPTH),
    .TEXT_WIDTH (TEXT_WIDTH)
  ) u_block_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cyphertext_i),
    .data_o  (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_idx     <= '0;
      block_done_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (xfer) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
      block_done_o <= pop;
      if (finish_i && !push) overflow_o <= 1'b1;
    end
  end

endmodule

// File: doc/cyphertext_serializer.md
Name: cyphertext_serializer

Overview:
Downstream stage of the AES encryption core. Captures each 128-bit ciphertext block when the core pulses its finish flag and buffers it in a small block FIFO. Streams the buffered blocks out one byte at a time, most significant byte first, over a valid/ready handshake. This decouples AES block timing from a byte-wide consumer such as a UART/ASCII writer or a narrow RAM port.

Parameters:
TEXT_WIDTH, 128, ciphertext block width in bits; same value as `TEXT_WIDTH in def.v.
BYTE_WIDTH, 8, output symbol width in bits.
DEPTH, 2, number of 128-bit block entries in the FIFO; must be a power of 2 and at least 2.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
finish_i  input  1  one-cycle block-complete strobe from the AES core.
cyphertext_i  input  TEXT_WIDTH  ciphertext block; sampled only when finish_i=1.
byte_o  output  BYTE_WIDTH  current output byte.
valid_o  output  1  byte_o holds valid data.
ready_i  input  1  consumer accepts byte_o this cycle.
block_done_o  output  1  one-cycle pulse, registered; the last byte of a block was transferred in the previous cycle.
count_o  output  log2(DEPTH)+1  number of occupied FIFO entries.
overflow_o  output  1  sticky flag; a block was dropped because the FIFO was full.

Behaviour:
- Reset values (asynchronous, while rst_ni=0): wr_ptr=0, rd_ptr=0, count=0, byte_idx=0, valid_o=0, byte_o=0, block_done_o=0, overflow_o=0. FIFO storage is not cleared.
- Reset mid-stream: a partially sent block is discarded. After reset, nothing is emitted until a new finish_i arrives.
- Push: occurs when finish_i=1 and push is allowed. Stores cyphertext_i at wr_ptr and increments wr_ptr modulo DEPTH.
  - Push is allowed when count<DEPTH.
  - Push is also allowed when count==DEPTH and a pop occurs in the same cycle.
- Transfer: occurs when valid_o=1 and ready_i=1. Increments byte_idx.
- Pop: a transfer with byte_idx==TEXT_WIDTH/BYTE_WIDTH-1 (15).
  - byte_idx returns to 0.
  - rd_ptr increments modulo DEPTH.
  - block_done_o=1 in the next cycle.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together or when neither occurs.
- Dropped block: finish_i=1 with count==DEPTH and no pop that cycle. The block is dropped, overflow_o is set to 1 and stays 1 until reset, and FIFO contents are unchanged.
- Output data: valid_o=(count!=0). byte_o = entry[rd_ptr][TEXT_WIDTH-1-BYTE_WIDTH*byte_idx -: BYTE_WIDTH].
  - Both are driven from registered state, so there is no combinational path from ready_i or finish_i to any output.
  - byte_o=0 when count==0.
- Latency: finish_i=1 at edge N gives valid_o=1 after edge N with byte_o=cyphertext_i[127:120]. Minimum 16 cycles per block with ready_i held at 1.
- Back-to-back: consecutive blocks stream with no bubble between byte 15 of one block and byte 0 of the next.
- Stalls: while ready_i=0, byte_o and valid_o hold, and byte_idx does not change.
- Push into an empty FIFO sets valid_o in the next cycle only; it is never valid in the same cycle.
- Pointer wrap: wr_ptr and rd_ptr wrap silently.

Decomposition:
- def.v gains `BYTE_WIDTH (8) and `SER_DEPTH (2), next to the existing `TEXT_WIDTH.
- One natural sub-module: block_fifo. It is a DEPTH x TEXT_WIDTH register FIFO with push/pop/count/full/empty.
- The byte index and handshake logic stay in cyphertext_serializer.

Test Plan:
1. Single block with ready_i=1: finish_i with 3925841d02dc09fbdc118597196a0b32 -> bytes 39,25,84,1d,...,0b,32 on 16 consecutive cycles; block_done_o pulses once; count_o returns to 0.
2. Backpressure: ready_i toggles 1,0,0,1,... -> byte sequence identical to scenario 1; byte_o is stable on every stall cycle; no byte is duplicated or skipped.
3. Overflow: ready_i=0, three finish_i strobes with blocks A, B, C -> count_o=2, overflow_o=1; after ready_i=1, A then B are output and C is never output.
4. Simultaneous push/pop: FIFO full, finish_i coincides with the transfer of byte 15 -> new block accepted, overflow_o stays 0, count_o stays 2.
5. Reset mid-block: assert rst_ni=0 after byte 5 -> valid_o=0 and count_o=0 immediately; next block starts cleanly from byte 0.
